// File: rtl/flash_arb_pkg.sv
// Shared types and pin idle values for the flash bus arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwnSpi,
    StOwnQspi,
    StGuard
  } arbState_e;

  typedef enum logic {
    OwnerSpi,
    OwnerQspi
  } owner_e;

  localparam logic [3:0] IDLE_DO = 4'b1100;
  localparam logic [3:0] IDLE_OE = 4'b1100;
  localparam logic [3:0] SPI_OE  = 4'b1101;

  // Undriven QSPI lanes fall back to the idle level, keeping HOLD/WP high.
  function automatic logic [3:0] qspiPinDo(logic [3:0] dataOut, logic [3:0] dataOe);
    return (dataOut & dataOe) | (IDLE_DO & ~dataOe);
  endfunction

endpackage

// File: rtl/flash_arb_timer.sv
// Saturating cycle counter shared by the hold-timeout and the inter-owner guard gap.
module flash_arb_timer #(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_W          = 21
) (
  input  logic iCLK,
  input  logic iRESET,
  input  logic iClear,
  input  logic iEnable,
  output logic oGuardDone,
  output logic oTimeoutHit
);

  localparam logic [CNT_W-1:0] GuardLast = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TmoLast   =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cntQ;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      cntQ <= '0;
    end else if (iClear) begin
      cntQ <= '0;
    end else if (iEnable && (cntQ != '1)) begin
      cntQ <= cntQ + CNT_W'(1);
    end
  end

  assign oGuardDone  = (cntQ == GuardLast);
  assign oTimeoutHit = (TIMEOUT_CYCLES != 0) && (cntQ == TmoLast);

endmodule

// File: rtl/flash_bus_arbiter.sv
// Request/grant ownership of the shared Q-SPI flash pins between the legacy SPI master
// and the QSPI controller, with a forced CS-high guard gap and a hold timeout.
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_W          = 21
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iSPI_REQ,
  output logic       oSPI_GNT,
  input  logic       iSPI_SCK,
  input  logic       iSPI_CS,
  input  logic       iSPI_MOSI,
  output logic       oSPI_MISO,
  input  logic       iQSPI_REQ,
  output logic       oQSPI_GNT,
  input  logic       iQSPI_SCK,
  input  logic       iQSPI_NCS,
  input  logic [3:0] iQSPI_DATAOUT,
  input  logic [3:0] iQSPI_DATAOE,
  output logic [3:0] oQSPI_DATAIN,
  output logic       oFLASH_SCK,
  output logic       oFLASH_CS,
  output logic [3:0] oFLASH_DO,
  output logic [3:0] oFLASH_OE,
  input  logic [3:0] iFLASH_DI,
  output logic       oBUSY,
  output logic       oTIMEOUT
);

  arbState_e stateQ;
  owner_e    lastQ;
  logic      spiGntQ, qspiGntQ, busyQ, timeoutQ, spiBlkQ, qspiBlkQ;

  logic spiElig, qspiElig, spiRel, qspiRel, ownExit, cntClear;
  logic guardDone, timeoutHit;

  assign spiElig  = iSPI_REQ & ~spiBlkQ;
  assign qspiElig = iQSPI_REQ & ~qspiBlkQ;
  // Release only at a transfer boundary: request gone and the owner's CS deasserted.
  assign spiRel   = ~iSPI_REQ & iSPI_CS;
  assign qspiRel  = ~iQSPI_REQ & iQSPI_NCS;
  assign ownExit  = ((stateQ == StOwnSpi) && (spiRel || timeoutHit)) ||
                    ((stateQ == StOwnQspi) && (qspiRel || timeoutHit));
  assign cntClear = (stateQ == StIdle) || ownExit;

  flash_arb_timer #(
    .GUARD_CYCLES  (GUARD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) uTimer (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iClear     (cntClear),
    .iEnable    (stateQ != StIdle),
    .oGuardDone (guardDone),
    .oTimeoutHit(timeoutHit)
  );

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      stateQ   <= StIdle;
      lastQ    <= OwnerQspi;
      spiGntQ  <= 1'b0;
      qspiGntQ <= 1'b0;
      busyQ    <= 1'b0;
      timeoutQ <= 1'b0;
      spiBlkQ  <= 1'b0;
      qspiBlkQ <= 1'b0;
    end else begin
      timeoutQ <= 1'b0;
      if (!iSPI_REQ)  spiBlkQ  <= 1'b0;
      if (!iQSPI_REQ) qspiBlkQ <= 1'b0;
      case (stateQ)
        StIdle: begin
          if (spiElig && (!qspiElig || (lastQ == OwnerQspi))) begin
            stateQ  <= StOwnSpi;
            spiGntQ <= 1'b1;
            lastQ   <= OwnerSpi;
            busyQ   <= 1'b1;
          end else if (qspiElig) begin
            stateQ   <= StOwnQspi;
            qspiGntQ <= 1'b1;
            lastQ    <= OwnerQspi;
            busyQ    <= 1'b1;
          end
        end
        StOwnSpi: begin
          if (spiRel || timeoutHit) begin
            stateQ  <= StGuard;
            spiGntQ <= 1'b0;
            if (!spiRel) begin
              timeoutQ <= 1'b1;
              spiBlkQ  <= 1'b1;
            end
          end
        end
        StOwnQspi: begin
          if (qspiRel || timeoutHit) begin
            stateQ   <= StGuard;
            qspiGntQ <= 1'b0;
            if (!qspiRel) begin
              timeoutQ <= 1'b1;
              qspiBlkQ <= 1'b1;
            end
          end
        end
        StGuard: begin
          if (guardDone) begin
            stateQ <= StIdle;
            busyQ  <= 1'b0;
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  always_comb begin
    oFLASH_SCK   = 1'b0;
    oFLASH_CS    = 1'b1;
    oFLASH_DO    = IDLE_DO;
    oFLASH_OE    = IDLE_OE;
    oSPI_MISO    = 1'b0;
    oQSPI_DATAIN = 4'b0000;
    case (stateQ)
      StOwnSpi: begin
        oFLASH_SCK = iSPI_SCK;
        oFLASH_CS  = iSPI_CS;
        oFLASH_DO  = {3'b110, iSPI_MOSI};
        oFLASH_OE  = SPI_OE;
        oSPI_MISO  = iFLASH_DI[1];
      end
      StOwnQspi: begin
        oFLASH_SCK   = iQSPI_SCK;
        oFLASH_CS    = iQSPI_NCS;
        oFLASH_DO    = qspiPinDo(iQSPI_DATAOUT, iQSPI_DATAOE);
        oFLASH_OE    = iQSPI_DATAOE | IDLE_OE;
        oQSPI_DATAIN = iFLASH_DI;
      end
      default: ;
    endcase
  end

  assign oSPI_GNT  = spiGntQ;
  assign oQSPI_GNT = qspiGntQ;
  assign oBUSY     = busyQ;
  assign oTIMEOUT  = timeoutQ;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Bench for flash_bus_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_flash_bus_arbiter;

  localparam int G = 4;
  localparam int T = 64;

  logic       iCLK = 1'b0;
  logic       iRESET = 1'b1;
  logic       iSPI_REQ = 1'b0, iSPI_SCK = 1'b0, iSPI_CS = 1'b1, iSPI_MOSI = 1'b0;
  logic       iQSPI_REQ = 1'b0, iQSPI_SCK = 1'b0, iQSPI_NCS = 1'b1;
  logic [3:0] iQSPI_DATAOUT = 4'h0, iQSPI_DATAOE = 4'h0, iFLASH_DI = 4'h0;
  logic       oSPI_GNT, oSPI_MISO, oQSPI_GNT, oFLASH_SCK, oFLASH_CS, oBUSY, oTIMEOUT;
  logic [3:0] oQSPI_DATAIN, oFLASH_DO, oFLASH_OE;

  flash_bus_arbiter #(
    .GUARD_CYCLES  (G),
    .TIMEOUT_CYCLES(T),
    .CNT_W         (21)
  ) dut (
    .iCLK         (iCLK),
    .iRESET       (iRESET),
    .iSPI_REQ     (iSPI_REQ),
    .oSPI_GNT     (oSPI_GNT),
    .iSPI_SCK     (iSPI_SCK),
    .iSPI_CS      (iSPI_CS),
    .iSPI_MOSI    (iSPI_MOSI),
    .oSPI_MISO    (oSPI_MISO),
    .iQSPI_REQ    (iQSPI_REQ),
    .oQSPI_GNT    (oQSPI_GNT),
    .iQSPI_SCK    (iQSPI_SCK),
    .iQSPI_NCS    (iQSPI_NCS),
    .iQSPI_DATAOUT(iQSPI_DATAOUT),
    .iQSPI_DATAOE (iQSPI_DATAOE),
    .oQSPI_DATAIN (oQSPI_DATAIN),
    .oFLASH_SCK   (oFLASH_SCK),
    .oFLASH_CS    (oFLASH_CS),
    .oFLASH_DO    (oFLASH_DO),
    .oFLASH_OE    (oFLASH_OE),
    .iFLASH_DI    (iFLASH_DI),
    .oBUSY        (oBUSY),
    .oTIMEOUT     (oTIMEOUT)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 owned, 2 guard; owner 0 none, 1 SPI, 2 QSPI.
  int mPhase = 0, mOwner = 0, mLast = 2, mHeld = 0, mGuardLeft = 0;
  bit mTmo = 0, mBlk1 = 0, mBlk2 = 0;

  task automatic modelReset();
    mPhase = 0; mOwner = 0; mLast = 2; mHeld = 0; mGuardLeft = 0;
    mTmo = 0; mBlk1 = 0; mBlk2 = 0;
  endtask

  task automatic modelStep();
    bit r1, r2, e1, e2, rel;
    int pick;
    r1 = iSPI_REQ;
    r2 = iQSPI_REQ;
    e1 = r1 && !mBlk1;
    e2 = r2 && !mBlk2;
    mTmo = 0;
    if (!r1) mBlk1 = 0;
    if (!r2) mBlk2 = 0;
    if (mPhase == 0) begin
      pick = 0;
      if (e1 && e2) pick = (mLast == 1) ? 2 : 1;
      else if (e1) pick = 1;
      else if (e2) pick = 2;
      if (pick != 0) begin
        mPhase = 1; mOwner = pick; mLast = pick; mHeld = 0;
      end
    end else if (mPhase == 1) begin
      rel = (mOwner == 1) ? (!r1 && iSPI_CS) : (!r2 && iQSPI_NCS);
      if (rel || (T != 0 && mHeld == T - 1)) begin
        if (!rel) begin
          mTmo = 1;
          if (mOwner == 1) mBlk1 = 1; else mBlk2 = 1;
        end
        mPhase = 2; mOwner = 0; mGuardLeft = G;
      end else begin
        mHeld++;
      end
    end else begin
      mGuardLeft--;
      if (mGuardLeft == 0) mPhase = 0;
    end
  endtask

  function automatic logic [18:0] expOut();
    logic sck, cs, miso;
    logic [3:0] din, dov, oev;
    sck = 0; cs = 1; miso = 0; din = 0; dov = 4'b1100; oev = 4'b1100;
    if (mOwner == 1) begin
      sck = iSPI_SCK; cs = iSPI_CS; miso = iFLASH_DI[1];
      dov = 4'b1100 + {3'b000, iSPI_MOSI};
      oev = 4'b1101;
    end else if (mOwner == 2) begin
      sck = iQSPI_SCK; cs = iQSPI_NCS; din = iFLASH_DI;
      for (int i = 0; i < 4; i++) begin
        oev[i] = iQSPI_DATAOE[i] || (i >= 2);
        dov[i] = iQSPI_DATAOE[i] ? iQSPI_DATAOUT[i] : (i >= 2);
      end
    end
    return {mOwner == 1, mOwner == 2, miso, din, sck, cs, dov, oev, mPhase != 0, mTmo};
  endfunction

  logic [18:0] actVec;
  assign actVec = {oSPI_GNT, oQSPI_GNT, oSPI_MISO, oQSPI_DATAIN, oFLASH_SCK, oFLASH_CS,
                   oFLASH_DO, oFLASH_OE, oBUSY, oTIMEOUT};

  initial forever begin
    @(posedge iCLK or posedge iRESET);
    if (iRESET) modelReset();
    else modelStep();
  end

  initial forever begin
    @(negedge iCLK);
    #2;
    chk("model", 32'(actVec), 32'(expOut()));
  end

  task automatic step();
    @(negedge iCLK);
    #3;
  endtask

  task automatic waitGnt(input bit qspi, input int maxCyc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (((qspi ? oQSPI_GNT : oSPI_GNT) == 1'b0) && n < maxCyc);
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    do begin
      step();
      n++;
    end while (oBUSY && n < maxCyc);
    chk("wait_idle", oBUSY, 0);
  endtask

  initial begin
    int n, held, gap, tmo, blkGnt;
    repeat (2) step();
    iRESET = 0;
    chk("rst_cs", oFLASH_CS, 1);
    chk("rst_do", oFLASH_DO, 4'b1100);
    chk("rst_oe", oFLASH_OE, 4'b1100);
    chk("rst_gnt", {oSPI_GNT, oQSPI_GNT}, 2'b00);

    // Lone SPI request.
    iSPI_REQ = 1; iFLASH_DI = 4'b1111;
    chk("spi_gnt_lat0", oSPI_GNT, 0);
    step();
    chk("spi_gnt_lat1", oSPI_GNT, 1);
    iSPI_CS = 0; iSPI_MOSI = 1; #1;
    chk("spi_do_mosi1", oFLASH_DO, 4'b1101);
    chk("spi_oe", oFLASH_OE, 4'b1101);
    chk("spi_qin_zero", oQSPI_DATAIN, 0);
    chk("spi_miso", oSPI_MISO, 1);
    step();
    iSPI_MOSI = 0; #1;
    chk("spi_do_mosi0", oFLASH_DO, 4'b1100);
    step();
    iSPI_REQ = 0; iSPI_CS = 1;
    waitIdle(20);

    // Round robin from reset.
    iRESET = 1; step(); iRESET = 0;
    iSPI_REQ = 1; iQSPI_REQ = 1;
    step();
    chk("rr_first_spi", {oSPI_GNT, oQSPI_GNT}, 2'b10);
    iSPI_REQ = 0;
    waitGnt(1, 20, n);
    chk("rr_then_qspi_lat", n, 6);
    iQSPI_REQ = 0;
    waitIdle(20);
    iSPI_REQ = 1; iQSPI_REQ = 1;
    step();
    chk("rr_again_spi", {oSPI_GNT, oQSPI_GNT}, 2'b10);
    iSPI_REQ = 0;
    waitGnt(1, 20, n);
    chk("rr2_qspi", oQSPI_GNT, 1);

    // QSPI drops REQ mid-transfer; release waits for NCS, then guard gap.
    iQSPI_NCS = 0; iQSPI_REQ = 0; iSPI_REQ = 1;
    held = 0;
    repeat (10) begin
      step();
      held += int'(oQSPI_GNT);
    end
    chk("hold_mid_xfer", held, 10);
    iQSPI_NCS = 1;
    gap = 0; n = 0;
    do begin
      step();
      n++;
      if (!oSPI_GNT && !oQSPI_GNT && oFLASH_CS) gap++;
    end while (!oSPI_GNT && n < 30);
    chk("guard_gap", gap, G + 1);
    chk("guard_spi_gnt", oSPI_GNT, 1);

    // SPI hogs the bus with CS low until timeout.
    iSPI_CS = 0;
    held = 1; n = 0;
    while (oSPI_GNT && n < 200) begin
      step();
      n++;
      if (oSPI_GNT) held++;
    end
    chk("tmo_hold_cycles", held, T);
    tmo = int'(oTIMEOUT); blkGnt = 0;
    repeat (20) begin
      step();
      tmo += int'(oTIMEOUT);
      blkGnt += int'(oSPI_GNT);
    end
    chk("tmo_pulse", tmo, 1);
    chk("tmo_blocked", blkGnt, 0);
    iSPI_REQ = 0; step(); iSPI_REQ = 1;
    waitGnt(0, 10, n);
    chk("tmo_regrant", oSPI_GNT, 1);
    iSPI_REQ = 0; iSPI_CS = 1;
    waitIdle(20);

    // Quad read.
    iQSPI_REQ = 1; iQSPI_NCS = 0; iQSPI_DATAOE = 4'b0000; iQSPI_DATAOUT = 4'b0011;
    iFLASH_DI = 4'b1010;
    waitGnt(1, 10, n);
    chk("qr_gnt", oQSPI_GNT, 1);
    chk("qr_oe", oFLASH_OE, 4'b1100);
    chk("qr_do", oFLASH_DO, 4'b1100);
    chk("qr_datain", oQSPI_DATAIN, 4'b1010);
    chk("qr_miso_zero", oSPI_MISO, 0);
    iQSPI_DATAOE = 4'b0011; iQSPI_DATAOUT = 4'b0001; #1;
    chk("qw_do", oFLASH_DO, 4'b1101);
    chk("qw_oe", oFLASH_OE, 4'b1111);

    // Reset while QSPI owns with NCS low.
    step();
    iRESET = 1; #1;
    chk("rst_mid_cs", oFLASH_CS, 1);
    chk("rst_mid_oe", oFLASH_OE, 4'b1100);
    chk("rst_mid_gnt", {oSPI_GNT, oQSPI_GNT}, 2'b00);
    step(); iRESET = 0;

    // Random traffic: fast toggling, then slow toggling to reach timeouts.
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 3000; c++) begin
        step();
        if (iRESET) iRESET = 0;
        else if ($urandom_range(0, 1499) == 0) iRESET = 1;
        if ($urandom_range(0, (ph == 0) ? 15 : 99) == 0) iSPI_REQ = ~iSPI_REQ;
        if ($urandom_range(0, (ph == 0) ? 15 : 99) == 0) iQSPI_REQ = ~iQSPI_REQ;
        if ($urandom_range(0, (ph == 0) ? 3 : 40) == 0) iSPI_CS = ~iSPI_CS;
        if ($urandom_range(0, (ph == 0) ? 3 : 40) == 0) iQSPI_NCS = ~iQSPI_NCS;
        iSPI_SCK = 1'($urandom); iQSPI_SCK = 1'($urandom); iSPI_MOSI = 1'($urandom);
        iQSPI_DATAOUT = 4'($urandom); iQSPI_DATAOE = 4'($urandom);
        iFLASH_DI = 4'($urandom);
      end
    end
    iRESET = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
